// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types, constants and bound helper for freq_meter
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  // Cycles spent flushing the synchronizer before a window opens.
  localparam int ARM_CYCLES = 3;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } bounds_t;

  // Acceptance band around the expected count; the low bound clamps at zero.
  function automatic bounds_t calc_bounds(input int exp_count, input int tol);
    bounds_t b;
    b.lo = (exp_count > tol) ? 32'(exp_count - tol) : 32'd0;
    b.hi = 32'(exp_count + tol);
    return b;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer plus rising-edge detector
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic dly;

  // Two flops for metastability, a third to see the previous synchronized level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign rise = sync2 & ~dly;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge counter with range check and lock status
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 84000,
  parameter int CNT_W       = 17,
  parameter int EXP_COUNT   = 27000,
  parameter int TOL         = 27,
  parameter int LOCK_RUNS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             err
);

  localparam bounds_t          BOUNDS    = calc_bounds(EXP_COUNT, TOL);
  localparam logic [63:0]      MAX_CNT   = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] LO        = BOUNDS.lo[CNT_W-1:0];
  localparam logic [CNT_W-1:0] HI        = BOUNDS.hi[CNT_W-1:0];
  localparam int               GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [1:0]       ARM_LOAD  = 2'(ARM_CYCLES - 1);
  localparam int               RUN_W     = $clog2(LOCK_RUNS + 1);
  localparam logic [RUN_W-1:0] LOCK_VAL  = RUN_W'(LOCK_RUNS);

  // An upper bound the counter can never reach would make the check meaningless.
  if ({32'd0, BOUNDS.hi} > MAX_CNT) begin : g_hi_too_wide
    $error("freq_meter: EXP_COUNT+TOL does not fit in CNT_W bits");
  end

  state_t            state;
  logic [1:0]        arm_cnt;
  logic [GATE_W-1:0] gate;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [RUN_W-1:0]  good_runs;
  logic              rise;
  logic              window_ok;

  sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Count including this cycle's edge, saturating so an over-fast input reads all-ones.
  always_comb begin
    cnt_next = edge_cnt;
    if (rise && !(&edge_cnt)) begin
      cnt_next = edge_cnt + 1'b1;
    end
  end

  assign window_ok = (cnt_next >= LO) && (cnt_next <= HI);
  assign locked    = (good_runs == LOCK_VAL);

  // Sequencer: arm, run contiguous windows, publish each result and track lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      arm_cnt     <= 2'd0;
      gate        <= '0;
      edge_cnt    <= '0;
      good_runs   <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      err         <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      err         <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        good_runs <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_ARM;
            arm_cnt <= ARM_LOAD;
          end
          ST_ARM: begin
            if (arm_cnt == 2'd0) begin
              state    <= ST_MEASURE;
              gate     <= GATE_LOAD;
              edge_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt - 1'b1;
            end
          end
          ST_MEASURE: begin
            if (gate == '0) begin
              count       <= cnt_next;
              in_range    <= window_ok;
              count_valid <= 1'b1;
              gate        <= GATE_LOAD;
              edge_cnt    <= '0;
              if (window_ok) begin
                if (!locked) begin
                  good_runs <= good_runs + 1'b1;
                end
              end else begin
                good_runs <= '0;
                err       <= locked;
              end
            end else begin
              gate     <= gate - 1'b1;
              edge_cnt <= cnt_next;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/freq_meter.md
# freq_meter

Clock-side frequency checker for the adc_card clocking path. Runs on the PLL-generated fabric clock and measures the frequency of an asynchronous input (nominally the 27 MHz board reference, or any divided PLL tap) by counting its rising edges over a fixed gate window. It reports each window's count, flags in-range/out-of-range against an expected value, and derives a `locked` status that the ADC capture logic uses before trusting its sample clock.

## Interface
Parameters:
- `GATE_CYCLES`, 84000: gate window length in `clk` cycles (1 ms at 84 MHz).
- `CNT_W`, 17: width of the edge counter and the `count` output.
- `EXP_COUNT`, 27000: expected edges per window.
- `TOL`, 27: allowed absolute deviation from `EXP_COUNT`.
- `LOCK_RUNS`, 4: consecutive in-range windows required before `locked` asserts.

Ports:
- `clk` in 1: fabric clock (PLL output). The block has this one clock only.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: level. High runs measurements back-to-back. Low stops and idles.
- `sig_in` in 1: asynchronous signal under measurement. Its frequency must be below `clk`/2.5.
- `count` out `CNT_W`: edge count of the last completed window.
- `count_valid` out 1: one-cycle pulse when `count` updates.
- `in_range` out 1: result of the range check on the last completed window.
- `locked` out 1: high after `LOCK_RUNS` consecutive in-range windows.
- `err` out 1: one-cycle pulse when a window fails the range check while `locked` was high.

## Operation
- Input path:
  - `sig_in` passes through a 2-FF synchronizer and then a delay FF.
  - `edge` = sync & ~delayed.
- States:
  - IDLE → ARM when `enable`=1.
  - ARM lasts 3 cycles to flush the synchronizer. Edges seen during ARM are discarded. ARM → MEASURE.
  - MEASURE:
    - Load `gate` = `GATE_CYCLES-1` on entry.
    - Each cycle, decrement `gate`. Increment `edge_cnt` on `edge`, saturating at all-ones.
  - Terminal cycle (`gate`==0): the edge in that cycle is included. Then:
    - Latch `count` and `in_range`, and pulse `count_valid`.
    - Reload `gate` and clear `edge_cnt` in the same cycle, so windows are contiguous and no sample is lost.
- Range check: `in_range` = (`count` ≥ LO) && (`count` ≤ HI).
  - LO = max(`EXP_COUNT`-`TOL`, 0), clamped at elaboration.
  - HI = `EXP_COUNT`+`TOL`. HI must fit in `CNT_W` bits; otherwise it is an elaboration error.
- Lock:
  - `good_runs` counts consecutive in-range windows, saturating at `LOCK_RUNS`.
  - `locked` = (`good_runs` == `LOCK_RUNS`).
  - An out-of-range window clears `good_runs`. If `locked` was 1, `err` pulses in the same cycle as `count_valid`.
- `enable` low in any state:
  - Next state is IDLE and the open window is abandoned (no `count_valid`).
  - `good_runs` and `locked` clear. `count` and `in_range` hold.
- Reset values: all outputs 0, state IDLE, counters 0.

## Timing
- `sig_in` to `edge`: 3 `clk` cycles.
- First `count_valid`: `enable` rise + 1 (IDLE→ARM) + 3 (ARM) + `GATE_CYCLES` cycles, registered.
- After that, `count_valid` pulses exactly every `GATE_CYCLES` cycles.
- `count`, `in_range`, `locked` and `err` all update on the same edge as `count_valid`. Outputs are registered.
- `rst_n` low mid-window: all state clears on that edge and no partial result is reported.
- `enable` toggled low then high: always re-enters through ARM.

## Structure
- `freq_meter_pkg`:
  - state enum (IDLE, ARM, MEASURE).
  - `ARM_CYCLES`=3.
  - function computing the clamped LO/HI bounds.
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge detector. Single clock, reset to 0.

## Test plan
Unless noted: `GATE_CYCLES`=100, `EXP_COUNT`=25, `TOL`=1, `LOCK_RUNS`=4, `sig_in` period 4 `clk`.
1. Reset, `enable`=0, `sig_in` toggling → all outputs stay 0 and no `count_valid` pulses.
2. `enable`=1 → `count_valid` every 100 cycles with `count`=25 and `in_range`=1; `locked` rises with the 4th `count_valid`.
3. After lock, switch to period 5 → next window `count`=20, `in_range`=0, `err` pulses 1 cycle, `locked`=0. Back to period 4 → `locked` returns after 4 windows.
4. Drop `enable` 50 cycles into a window → no `count_valid` for it, `locked`=0, `count` holds 25. Re-enable → first result 104 cycles later.
5. `sig_in` constant 1 → `count`=0. With `CNT_W`=4, `EXP_COUNT`=10, `TOL`=5, period 2 → `count`=15 (saturated), `in_range`=1.
6. `rst_n` low for 1 cycle mid-window while locked → all outputs 0 next cycle; measurement resumes via ARM.
